// File: rtl/psum_fifo.sv
// ============================================================================
// Module   : psum_fifo
// Purpose  : First-word-fall-through partial-sum FIFO between vertically
//            adjacent PEs. It has sticky overflow/underflow flags.
// Options  : PSUM_FIFO_BYPASS_EN - an empty FIFO passes pushed data straight
//            to dout/empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic is_empty;
  logic is_full;
  logic pass_through;
  logic wr_en;
  logic rd_en;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);

`ifdef PSUM_FIFO_BYPASS_EN
  assign pass_through = is_empty & push & pop;
`else
  assign pass_through = 1'b0;
`endif

  // A pop frees the slot when the FIFO is full, so a simultaneous push is still accepted.
  assign wr_en = ~clear & push & (~is_full | pop) & ~pass_through;
  assign rd_en = ~clear & pop & ~is_empty;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
      if (push & ~pop & is_full)             overflow_d  = 1'b1;
      if (pop & is_empty & ~pass_through)    underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // The storage array is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  always_comb begin
    dout  = is_empty ? '0 : mem_q[rd_ptr_q];
    empty = is_empty;
`ifdef PSUM_FIFO_BYPASS_EN
    if (reset && is_empty && push) begin
      dout  = din;
      empty = 1'b0;
    end
`endif
  end

  assign full      = is_full;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_psum_fifo.sv
// ============================================================================
// Module   : tb_psum_fifo
// Purpose  : Bench for psum_fifo. A queue-based reference model and scoreboard
//            check the outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full, empty, overflow, underflow;
  logic [DW-1:0] dout;
  logic [CW-1:0] count;

  psum_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .push(push), .din(din), .full(full),
    .pop(pop), .dout(dout), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] dout;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } obs_t;

  obs_t          exp_q[$];
  logic [DW-1:0] ref_q[$];
  bit            ref_ovf, ref_unf;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic obs_t sample_dut();
    obs_t o;
    o.dout = dout; o.count = count; o.full = full;
    o.empty = empty; o.ovf = overflow; o.unf = underflow;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got dout=%h count=%0d full=%b empty=%b ovf=%b unf=%b, expected dout=%h count=%0d full=%b empty=%b ovf=%b unf=%b",
               name, $time, act.dout, act.count, act.full, act.empty, act.ovf, act.unf,
               exp.dout, exp.count, exp.full, exp.empty, exp.ovf, exp.unf);
    end
  endtask

  function automatic obs_t reset_view();
    obs_t o;
    o = '0;
    o.empty = 1'b1;
    return o;
  endfunction

  // Monitor: compares what the DUT presents against the next scoreboard entry.
  always @(negedge clk) begin
    if (reset && exp_q.size() > 0) check("cycle", sample_dut(), exp_q.pop_front());
  end

  // One cycle of stimulus. The expected view is queued, and then the model advances past the next edge.
  task automatic step(input bit ps, input bit pp, input logic [DW-1:0] d, input bit clr);
    obs_t e;
    int   sz;
    @(posedge clk); #1;
    push = ps; pop = pp; din = d; clear = clr;
    sz = ref_q.size();
    e.count = CW'(sz);
    e.full  = (sz == DEPTH);
    e.empty = (sz == 0);
    e.dout  = (sz == 0) ? '0 : ref_q[0];
    e.ovf   = ref_ovf;
    e.unf   = ref_unf;
`ifdef PSUM_FIFO_BYPASS_EN
    if (sz == 0 && ps) begin e.dout = d; e.empty = 1'b0; end
`endif
    exp_q.push_back(e);
    if (clr) begin
      ref_q.delete(); ref_ovf = 0; ref_unf = 0;
    end else begin
`ifdef PSUM_FIFO_BYPASS_EN
      if (!(sz == 0 && ps && pp)) begin
`else
      begin
`endif
        if (pp) begin
          if (sz == 0) ref_unf = 1;
          else void'(ref_q.pop_front());
        end
        if (ps) begin
          if (sz == DEPTH && !pp) ref_ovf = 1;
          else ref_q.push_back(d);
        end
      end
    end
  endtask

  task automatic idle();
    step(0, 0, '0, 0);
  endtask

  // Asynchronous reset that lands mid-cycle; the outputs must collapse at once.
  task automatic async_reset(input string name);
    @(posedge clk); #2;
    push = 0; pop = 0; clear = 0; din = '0;
    reset = 1'b0;
    #1 check(name, sample_dut(), reset_view());
    ref_q.delete(); ref_ovf = 0; ref_unf = 0;
    repeat (2) @(posedge clk);
    #1 check({name, "_hold"}, sample_dut(), reset_view());
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, scoreboard has %0d entries", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int bias_push, bias_pop;
    #2 check("reset_init", sample_dut(), reset_view());
    @(negedge clk);
    reset = 1'b1;

    // Test 1: reset while two words are held, then a push after release.
    step(1, 0, 16'h0A01, 0);
    step(1, 0, 16'h0A02, 0);
    async_reset("reset_mid");
    step(1, 0, 16'h0011, 0);
    idle();

    // Test 2: fill in order, then drain in order.
    step(0, 0, '0, 1);
    for (int i = 1; i <= 4; i++) step(1, 0, DW'(i), 0);
    for (int i = 0; i < 4; i++) step(0, 1, '0, 0);
    idle();

    // Test 3: keep the FIFO full with push and pop together across pointer wrap.
    for (int i = 0; i < 4; i++) step(1, 0, DW'(16'h0010 + i), 0);
    for (int i = 0; i < 6; i++) step(1, 1, 16'h00AA, 0);
    for (int i = 0; i < 4; i++) step(0, 1, '0, 0);
    idle();

    // Test 4: overflow, underflow, and clear.
    for (int i = 0; i < 4; i++) step(1, 0, DW'(16'h0020 + i), 0);
    step(1, 0, 16'hBEEF, 0);
    for (int i = 0; i < 4; i++) step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    idle();
    step(1, 1, 16'h5555, 1);
    idle();

    // Test 5: push and pop together while empty.
    step(1, 1, 16'h1234, 0);
    idle();
    step(0, 1, '0, 0);
    step(0, 0, '0, 1);
    idle();

    // Test 6: random traffic, with the push/pop bias changed so both ends are reached.
    bias_push = 50; bias_pop = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 250 == 0) begin
        bias_push = $urandom_range(15, 85);
        bias_pop  = $urandom_range(15, 85);
      end
      step($urandom_range(0, 99) < bias_push, $urandom_range(0, 99) < bias_pop,
           DW'($urandom), $urandom_range(0, 299) == 0);
      if (c == 5000) async_reset("reset_random");
    end
    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
